rbi_mem_req_node: RTL and testbench
===================================

RBI_MEM_REQ_NODE -- requirements
Module: rbi_mem_req_node

Interface
REQ-001 SHALL have parameter ADDR_W, default 48: ring address width in bits.
REQ-002 SHALL have parameter DATA_W, default 128: ring tile width in bits.
REQ-003 SHALL have parameter TMO_MAX, default 1023: response timeout in cycles.
REQ-004 SHALL have port clock, input, 1 bit: sole clock.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have ring ingress ports memSeqIn, memOpmIn, memAddrIn and memDataIn, all inputs, widths 16, 16, ADDR_W and DATA_W.
REQ-007 SHALL have ring egress ports memSeqOut, memOpmOut, memAddrOut and memDataOut, all outputs, same widths as REQ-006.
REQ-008 SHALL have port unitNodeId, input, 8 bits: this node's ring ID.
REQ-009 SHALL have local request ports reqValid (input, 1), reqReady (output, 1), reqOpm (input, 8), reqAddr (input, ADDR_W) and reqData (input, DATA_W).
REQ-010 SHALL have local response ports rspValid (output, 1), rspTag (output, 2), rspData (output, DATA_W) and rspErr (output, 1).
REQ-011 SHALL have port reqTag, output, 2 bits: tag assigned to the request accepted this cycle.

Function
REQ-012 Ring stage SHALL be fully registered: ingress-to-egress latency exactly 1 cycle.
REQ-013 A slot with memOpmIn[7:0]==0 SHALL be empty.
REQ-014 A slot with memOpmIn[7:6]==2'b01 SHALL be a response.
REQ-015 Sequence format SHALL be memSeq[15:8]=source node ID, memSeq[3:2]=0, memSeq[1:0]=tag.
REQ-016 Outstanding table SHALL hold 4 entries; each entry holds a valid bit and a 10-bit age counter.
REQ-017 reqReady SHALL equal (hold register empty) AND (at least one tag free).
REQ-018 On reqValid&&reqReady: latch the request into a 1-entry hold register, allocate the lowest free tag, mark it valid, clear its age, and drive reqTag with it in the same cycle.
REQ-019 Own response (response slot with memSeqIn[15:8]==unitNodeId and its tag valid) SHALL, next cycle: pulse rspValid=1, rspErr=0, rspTag=tag, rspData=memDataIn; free the tag; output an empty slot.
REQ-020 Own response with an invalid tag SHALL be consumed silently: no rspValid, empty slot out.
REQ-021 The hold register SHALL inject when the ingress slot is empty, or is freed per REQ-019/REQ-020 that cycle.
REQ-022 Injected slot contents SHALL be: Opm={memOpmIn[15],7'b0,reqOpm}; Seq={unitNodeId,6'b0,tag}; Addr=reqAddr; Data=reqData (STX) or 0 (other opcodes).
REQ-023 All other slots SHALL be forwarded unchanged, including Opm[15] and the bits [14:8].
REQ-024 Each valid entry's age SHALL increment once per cycle.
REQ-025 Age==TMO_MAX SHALL free the tag and pulse rspValid=1, rspErr=1, rspData=0.
REQ-026 Timeout and matching response for the same tag in the same cycle: the response SHALL win (rspErr=0).
REQ-027 Two completions in one cycle SHALL be priority-ordered response > lowest-tag timeout; the losing timeout SHALL be deferred 1 cycle with its age held.
REQ-028 Tags SHALL be reusable the cycle after they are freed.
REQ-029 With the table full, reqReady SHALL be 0; a pending hold register still injects its already-tagged request.

Reset
REQ-030 While reset is low, every output and all state SHALL be 0: mem*Out, rspValid, rspTag, rspData, rspErr, reqTag, hold valid, table valid bits, age counters.
REQ-031 Reset asserted mid-operation SHALL drop all outstanding entries with no rspValid; late responses after reset deasserts are handled per REQ-020.

Structure
REQ-032 Opcode constants (JX2_RBI_OPM_LDX/STX/PFX/SPX), the response class value 2'b01, and the sequence field positions SHALL live in the shared ringbus definitions package.
REQ-033 The outstanding table with its allocator and ages SHALL be one sub-module, rbi_req_tag_table.

Verification
REQ-034 Idle ring, unitNodeId=8'h10, LDX addr 0x1000: empty slot -> egress Seq=16'h1000, Addr 0x1000, 1 cycle later; response with Seq 16'h1000, Data 0xAA -> rspValid, rspTag=0, rspData=0xAA, rspErr=0.
REQ-035 Four back-to-back requests, no responses -> tags 0,1,2,3, then reqReady=0; response for tag 2 -> reqReady=1, next request gets tag 2.
REQ-036 Foreign slot Seq=16'h2201 with Opm[15]=1 -> forwarded bit-exact after 1 cycle, no rspValid.
REQ-037 No response for TMO_MAX cycles -> rspErr=1 pulse, rspData=0, tag freed; response arriving in the same cycle instead -> rspErr=0.
REQ-038 Own response and pending hold in the same cycle -> rspValid and injection of the new request in the same egress slot.
REQ-039 Reset low with 3 tags outstanding -> all outputs 0; post-reset response Seq=16'h1001 -> consumed, no rspValid.

Source files
------------

// File: rtl/rbi_mem_req_node_pkg.sv
// Shared ringbus definitions: opcodes, slot-class encoding, sequence field layout
// and small field helpers used by the memory request node.
package rbi_mem_req_node_pkg;

    localparam logic [7:0] JX2_RBI_OPM_LDX = 8'h93;
    localparam logic [7:0] JX2_RBI_OPM_STX = 8'h97;
    localparam logic [7:0] JX2_RBI_OPM_PFX = 8'h9B;
    localparam logic [7:0] JX2_RBI_OPM_SPX = 8'h9F;

    localparam logic [1:0] RBI_OPM_CLS_RSP = 2'b01;
    localparam int unsigned RBI_OPM_CLS_LSB = 6;
    localparam int unsigned RBI_OPM_CLS_MSB = 7;

    localparam int unsigned RBI_SEQ_NODE_LSB = 8;
    localparam int unsigned RBI_SEQ_NODE_MSB = 15;
    localparam int unsigned RBI_SEQ_RSV_LSB  = 2;
    localparam int unsigned RBI_SEQ_RSV_MSB  = 3;
    localparam int unsigned RBI_SEQ_TAG_LSB  = 0;
    localparam int unsigned RBI_SEQ_TAG_MSB  = 1;

    localparam int unsigned RBI_TAG_W    = 2;
    localparam int unsigned RBI_NUM_TAGS = 4;
    localparam int unsigned RBI_AGE_W    = 10;

    typedef logic [RBI_TAG_W-1:0] rbi_tag_t;

    typedef enum logic [1:0] {
        SLOT_FWD     = 2'd0,
        SLOT_EMPTY   = 2'd1,
        SLOT_OWN_RSP = 2'd2
    } rbi_slot_cls_t;

    function automatic logic rbi_opm_is_empty(input logic [15:0] opm);
        return (opm[7:0] == 8'h00);
    endfunction

    function automatic logic rbi_opm_is_rsp(input logic [15:0] opm);
        return (opm[RBI_OPM_CLS_MSB:RBI_OPM_CLS_LSB] == RBI_OPM_CLS_RSP);
    endfunction

    function automatic logic [7:0] rbi_seq_node(input logic [15:0] seq);
        return seq[RBI_SEQ_NODE_MSB:RBI_SEQ_NODE_LSB];
    endfunction

    function automatic rbi_tag_t rbi_seq_tag(input logic [15:0] seq);
        return seq[RBI_SEQ_TAG_MSB:RBI_SEQ_TAG_LSB];
    endfunction

    function automatic logic [15:0] rbi_mk_seq(input logic [7:0] node, input rbi_tag_t tag);
        return {node, 6'b000000, tag};
    endfunction

    // Lowest set bit of a 4-entry mask; mask must be non-zero for a meaningful result
    function automatic rbi_tag_t rbi_lowest_tag(input logic [3:0] mask);
        casez (mask)
            4'b???1: return 2'd0;
            4'b??10: return 2'd1;
            4'b?100: return 2'd2;
            4'b1000: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/rbi_req_tag_table.sv
// Outstanding-request table: four tags with valid bits and age counters,
// lowest-free allocator and single-completion arbiter (response beats timeout).
module rbi_req_tag_table
    import rbi_mem_req_node_pkg::*;
#(
    parameter int unsigned TMO_MAX = 1023
) (
    input  logic     clock,
    input  logic     reset,
    input  logic     allocEn,
    output rbi_tag_t allocTag,
    output logic     anyFree,
    input  logic     rspHit,
    input  rbi_tag_t rspTag,
    output logic     cplValid,
    output rbi_tag_t cplTag,
    output logic     cplErr
);

    localparam logic [RBI_AGE_W-1:0] AGE_LIMIT = RBI_AGE_W'(TMO_MAX);

    logic [RBI_NUM_TAGS-1:0] valid_r;
    logic [RBI_AGE_W-1:0]    age_r [RBI_NUM_TAGS];
    logic [RBI_NUM_TAGS-1:0] tmoHit_s;
    logic [RBI_NUM_TAGS-1:0] freeMask_s;
    logic                    rspDone_s;

    assign anyFree  = ~(&valid_r);
    assign allocTag = rbi_lowest_tag(~valid_r);

    // Pick at most one completion; a timeout on the tag being answered is absorbed
    always_comb begin
        rspDone_s = rspHit && valid_r[rspTag];
        for (int i = 0; i < RBI_NUM_TAGS; i++) begin
            tmoHit_s[i] = valid_r[i] && (age_r[i] == AGE_LIMIT) &&
                          !(rspDone_s && (rspTag == rbi_tag_t'(i)));
        end
        if (rspDone_s) begin
            cplValid = 1'b1;
            cplTag   = rspTag;
            cplErr   = 1'b0;
        end else if (|tmoHit_s) begin
            cplValid = 1'b1;
            cplTag   = rbi_lowest_tag(tmoHit_s);
            cplErr   = 1'b1;
        end else begin
            cplValid = 1'b0;
            cplTag   = 2'd0;
            cplErr   = 1'b0;
        end
        freeMask_s = cplValid ? (4'b0001 << cplTag) : 4'b0000;
    end

    // Entry state; ages saturate at the limit so a deferred timeout keeps its age
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_r <= 4'b0000;
            for (int i = 0; i < RBI_NUM_TAGS; i++) begin
                age_r[i] <= {RBI_AGE_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < RBI_NUM_TAGS; i++) begin
                if (allocEn && (allocTag == rbi_tag_t'(i))) begin
                    valid_r[i] <= 1'b1;
                    age_r[i]   <= {RBI_AGE_W{1'b0}};
                end else if (freeMask_s[i]) begin
                    valid_r[i] <= 1'b0;
                    age_r[i]   <= {RBI_AGE_W{1'b0}};
                end else if (valid_r[i] && (age_r[i] != AGE_LIMIT)) begin
                    age_r[i] <= age_r[i] + RBI_AGE_W'(1);
                end else begin
                    age_r[i] <= age_r[i];
                end
            end
        end
    end

endmodule

// File: rtl/rbi_mem_req_node.sv
// Ring-bus memory request node: registered ring stage, one-entry request hold
// register with slot injection, and own-response / timeout reporting.
module rbi_mem_req_node
    import rbi_mem_req_node_pkg::*;
#(
    parameter int unsigned ADDR_W  = 48,
    parameter int unsigned DATA_W  = 128,
    parameter int unsigned TMO_MAX = 1023
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [15:0]       memSeqIn,
    input  logic [15:0]       memOpmIn,
    input  logic [ADDR_W-1:0] memAddrIn,
    input  logic [DATA_W-1:0] memDataIn,
    output logic [15:0]       memSeqOut,
    output logic [15:0]       memOpmOut,
    output logic [ADDR_W-1:0] memAddrOut,
    output logic [DATA_W-1:0] memDataOut,
    input  logic [7:0]        unitNodeId,
    input  logic              reqValid,
    output logic              reqReady,
    input  logic [7:0]        reqOpm,
    input  logic [ADDR_W-1:0] reqAddr,
    input  logic [DATA_W-1:0] reqData,
    output logic              rspValid,
    output logic [1:0]        rspTag,
    output logic [DATA_W-1:0] rspData,
    output logic              rspErr,
    output logic [1:0]        reqTag
);

    rbi_slot_cls_t     slotCls_s;
    logic              ownRsp_s;
    logic              slotFree_s;
    logic              inject_s;
    logic              accept_s;
    logic              anyFree_s;
    rbi_tag_t          allocTag_s;
    rbi_tag_t          rspTagIn_s;
    rbi_tag_t          cplTag_s;
    logic              cplValid_s;
    logic              cplErr_s;

    logic              holdValid_r;
    logic [7:0]        holdOpm_r;
    rbi_tag_t          holdTag_r;
    logic [ADDR_W-1:0] holdAddr_r;
    logic [DATA_W-1:0] holdData_r;

    logic [15:0]       seqNext_s;
    logic [15:0]       opmNext_s;
    logic [ADDR_W-1:0] addrNext_s;
    logic [DATA_W-1:0] dataNext_s;

    // Classify the ingress slot
    always_comb begin
        if (rbi_opm_is_empty(memOpmIn)) begin
            slotCls_s = SLOT_EMPTY;
        end else if (rbi_opm_is_rsp(memOpmIn) && (rbi_seq_node(memSeqIn) == unitNodeId)) begin
            slotCls_s = SLOT_OWN_RSP;
        end else begin
            slotCls_s = SLOT_FWD;
        end
    end

    // An own response is always consumed, so its slot is free for injection
    always_comb begin
        ownRsp_s   = 1'b0;
        slotFree_s = 1'b0;
        case (slotCls_s)
            SLOT_EMPTY: begin
                slotFree_s = 1'b1;
            end
            SLOT_OWN_RSP: begin
                ownRsp_s   = 1'b1;
                slotFree_s = 1'b1;
            end
            default: begin
                ownRsp_s   = 1'b0;
                slotFree_s = 1'b0;
            end
        endcase
    end

    assign rspTagIn_s = rbi_seq_tag(memSeqIn);
    assign inject_s   = holdValid_r && slotFree_s;
    assign reqReady   = !holdValid_r && anyFree_s;
    assign accept_s   = reqValid && reqReady;
    assign reqTag     = accept_s ? allocTag_s : 2'd0;

    rbi_req_tag_table #(
        .TMO_MAX (TMO_MAX)
    ) u_tagTable (
        .clock    (clock),
        .reset    (reset),
        .allocEn  (accept_s),
        .allocTag (allocTag_s),
        .anyFree  (anyFree_s),
        .rspHit   (ownRsp_s),
        .rspTag   (rspTagIn_s),
        .cplValid (cplValid_s),
        .cplTag   (cplTag_s),
        .cplErr   (cplErr_s)
    );

    // Hold register: keeps an accepted, already-tagged request until a slot frees up
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            holdValid_r <= 1'b0;
            holdOpm_r   <= 8'h00;
            holdTag_r   <= 2'd0;
            holdAddr_r  <= {ADDR_W{1'b0}};
            holdData_r  <= {DATA_W{1'b0}};
        end else if (accept_s) begin
            holdValid_r <= 1'b1;
            holdOpm_r   <= reqOpm;
            holdTag_r   <= allocTag_s;
            holdAddr_r  <= reqAddr;
            holdData_r  <= (reqOpm == JX2_RBI_OPM_STX) ? reqData : {DATA_W{1'b0}};
        end else if (inject_s) begin
            holdValid_r <= 1'b0;
        end else begin
            holdValid_r <= holdValid_r;
        end
    end

    // Next egress slot; Opm[15] belongs to the ring and survives injection/consumption
    always_comb begin
        seqNext_s  = memSeqIn;
        opmNext_s  = memOpmIn;
        addrNext_s = memAddrIn;
        dataNext_s = memDataIn;
        if (inject_s) begin
            opmNext_s  = {memOpmIn[15], 7'b0000000, holdOpm_r};
            seqNext_s  = rbi_mk_seq(unitNodeId, holdTag_r);
            addrNext_s = holdAddr_r;
            dataNext_s = holdData_r;
        end else if (ownRsp_s) begin
            opmNext_s  = {memOpmIn[15], 15'h0000};
            seqNext_s  = 16'h0000;
            addrNext_s = {ADDR_W{1'b0}};
            dataNext_s = {DATA_W{1'b0}};
        end else begin
            opmNext_s  = memOpmIn;
        end
    end

    // Registered ring stage
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            memSeqOut  <= 16'h0000;
            memOpmOut  <= 16'h0000;
            memAddrOut <= {ADDR_W{1'b0}};
            memDataOut <= {DATA_W{1'b0}};
        end else begin
            memSeqOut  <= seqNext_s;
            memOpmOut  <= opmNext_s;
            memAddrOut <= addrNext_s;
            memDataOut <= dataNext_s;
        end
    end

    // Registered completion report; timeouts carry zero data
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rspValid <= 1'b0;
            rspTag   <= 2'd0;
            rspErr   <= 1'b0;
            rspData  <= {DATA_W{1'b0}};
        end else begin
            rspValid <= cplValid_s;
            rspTag   <= cplTag_s;
            rspErr   <= cplErr_s;
            rspData  <= (cplValid_s && !cplErr_s) ? memDataIn : {DATA_W{1'b0}};
        end
    end

endmodule

// File: tb/tb_rbi_mem_req_node.sv
// Directed bench for rbi_mem_req_node: responses go through a scoreboard queue
// checked by an independent monitor; ring egress is checked in line.
module tb_rbi_mem_req_node;
    import rbi_mem_req_node_pkg::*;

    localparam int ADDR_W = 48;
    localparam int DATA_W = 128;
    localparam int TMO    = 40;
    localparam logic [7:0] NODE = 8'h10;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic [15:0]       memSeqIn, memOpmIn, memSeqOut, memOpmOut;
    logic [ADDR_W-1:0] memAddrIn, memAddrOut, reqAddr;
    logic [DATA_W-1:0] memDataIn, memDataOut, reqData, rspData;
    logic [7:0]        unitNodeId, reqOpm;
    logic              reqValid, reqReady, rspValid, rspErr;
    logic [1:0]        rspTag, reqTag;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [1:0]        tag;
        logic [DATA_W-1:0] data;
        logic              err;
        int                at;
    } exp_t;
    exp_t expQ[$];

    rbi_mem_req_node #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TMO_MAX(TMO)) dut (
        .clock(clock), .reset(reset),
        .memSeqIn(memSeqIn), .memOpmIn(memOpmIn), .memAddrIn(memAddrIn), .memDataIn(memDataIn),
        .memSeqOut(memSeqOut), .memOpmOut(memOpmOut), .memAddrOut(memAddrOut), .memDataOut(memDataOut),
        .unitNodeId(unitNodeId),
        .reqValid(reqValid), .reqReady(reqReady), .reqOpm(reqOpm), .reqAddr(reqAddr), .reqData(reqData),
        .rspValid(rspValid), .rspTag(rspTag), .rspData(rspData), .rspErr(rspErr),
        .reqTag(reqTag)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Response monitor: every rspValid pulse must match the head of the scoreboard
    always @(negedge clock) begin
        exp_t e;
        if (rspValid) begin
            total++;
            if (expQ.size() == 0) begin
                bad++;
                $display("FAIL rsp_unexpected: got tag=%0d err=%0b data=%h cyc=%0d, required no response",
                         rspTag, rspErr, rspData, cyc);
            end else begin
                e = expQ.pop_front();
                if (rspTag !== e.tag || rspData !== e.data || rspErr !== e.err || e.at != cyc) begin
                    bad++;
                    $display("FAIL rsp_match: got tag=%0d err=%0b data=%h cyc=%0d, required tag=%0d err=%0b data=%h cyc=%0d",
                             rspTag, rspErr, rspData, cyc, e.tag, e.err, e.data, e.at);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic ring(input logic [15:0] opm, input logic [15:0] seq,
                        input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        memOpmIn  = opm;
        memSeqIn  = seq;
        memAddrIn = a;
        memDataIn = d;
    endtask

    task automatic idle();
        ring(16'h0000, 16'h0000, 48'h0, 128'h0);
    endtask

    task automatic chkEgress(input string nm, input logic [15:0] opm, input logic [15:0] seq,
                             input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        chk({nm, ".opm"},  128'(memOpmOut),  128'(opm));
        chk({nm, ".seq"},  128'(memSeqOut),  128'(seq));
        chk({nm, ".addr"}, 128'(memAddrOut), 128'(a));
        chk({nm, ".data"}, memDataOut, d);
    endtask

    task automatic chkAllZero(input string nm);
        chkEgress(nm, 16'h0000, 16'h0000, 48'h0, 128'h0);
        chk({nm, ".rspValid"}, 128'(rspValid), 128'h0);
        chk({nm, ".rspTag"},   128'(rspTag),   128'h0);
        chk({nm, ".rspData"},  rspData,        128'h0);
        chk({nm, ".rspErr"},   128'(rspErr),   128'h0);
        chk({nm, ".reqTag"},   128'(reqTag),   128'h0);
    endtask

    // Present a request, wait (bounded) for reqReady, check its tag; returns the accept cycle
    task automatic issue(input logic [7:0] opm, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input logic [1:0] expTag, output int acc);
        int n;
        n = 0;
        reqValid = 1'b1;
        reqOpm   = opm;
        reqAddr  = a;
        reqData  = d;
        #1;
        while (!reqReady && n < 50) begin
            step();
            n++;
        end
        chk("issue_ready", 128'(reqReady), 128'h1);
        chk("issue_reqTag", 128'(reqTag), 128'(expTag));
        step();
        acc = cyc;
        reqValid = 1'b0;
    endtask

    // Own response on the ring for tag t, expected to be reported next cycle
    task automatic respond(input logic [15:0] opm, input logic [1:0] t, input logic [DATA_W-1:0] d);
        ring(opm, {NODE, 6'b000000, t}, 48'h0, d);
        expQ.push_back('{t, d, 1'b0, cyc + 1});
        step();
        idle();
    endtask

    initial begin
        int a, a1, n;
        unitNodeId = NODE;
        reqValid = 1'b0;
        reqOpm = 8'h00;
        reqAddr = 48'h0;
        reqData = 128'h0;
        // traffic on the ring during reset must not reach the egress
        ring(16'h8093, 16'h2201, 48'h55, 128'h55);
        repeat (3) step();
        chkAllZero("reset_init");
        idle();
        reset = 1'b1;
        step();

        // Single LDX round trip
        issue(JX2_RBI_OPM_LDX, 48'h1000, 128'h55, 2'd0, a);
        step();
        chkEgress("t1_inject", {8'h00, JX2_RBI_OPM_LDX}, 16'h1000, 48'h1000, 128'h0);
        respond(16'h0040, 2'd0, 128'hAA);
        chkEgress("t1_consumed", 16'h0000, 16'h0000, 48'h0, 128'h0);
        chk("t1_ready", 128'(reqReady), 128'h1);

        // Fill all four tags, free tag 2, reuse it
        for (int t = 0; t < 4; t++) begin
            issue(JX2_RBI_OPM_LDX, 48'h2000 + 48'(t), 128'h0, t[1:0], a);
            step();
            chkEgress("t2_inject", {8'h00, JX2_RBI_OPM_LDX}, {NODE, 6'b000000, t[1:0]},
                      48'h2000 + 48'(t), 128'h0);
        end
        chk("t2_full_not_ready", 128'(reqReady), 128'h0);
        respond(16'h0040, 2'd2, 128'h22);
        chk("t2_freed_ready", 128'(reqReady), 128'h1);
        issue(JX2_RBI_OPM_STX, 48'h2100, 128'h77, 2'd2, a);
        step();
        chkEgress("t2_reuse", {8'h00, JX2_RBI_OPM_STX}, 16'h1002, 48'h2100, 128'h77);
        for (int t = 0; t < 4; t++) begin
            respond(16'h0040, t[1:0], 128'h30 + 128'(t));
        end

        // Foreign slots pass through bit-exact
        ring(16'hA593, 16'h2201, 48'h123456789ABC, 128'h0123456789ABCDEF_FEDCBA9876543210);
        step();
        chkEgress("t3_fwd_req", 16'hA593, 16'h2201, 48'h123456789ABC, 128'h0123456789ABCDEF_FEDCBA9876543210);
        ring(16'h8040, 16'h2203, 48'h9, 128'h5A5A);
        step();
        idle();
        chkEgress("t3_fwd_rsp", 16'h8040, 16'h2203, 48'h9, 128'h5A5A);

        // Timeout with no response
        issue(JX2_RBI_OPM_LDX, 48'h3000, 128'h99, 2'd0, a);
        expQ.push_back('{2'd0, 128'h0, 1'b1, a + TMO + 1});
        n = 0;
        while (expQ.size() != 0 && n < 3 * TMO) begin
            step();
            n++;
        end
        chk("t4_timeout_seen", 128'(expQ.size()), 128'h0);
        chk("t4_freed_ready", 128'(reqReady), 128'h1);

        // Response lands in the timeout cycle: response wins
        issue(JX2_RBI_OPM_LDX, 48'h3100, 128'h0, 2'd0, a);
        while (cyc < a + TMO) step();
        respond(16'h0040, 2'd0, 128'hBB);
        repeat (5) step();

        // Response for tag 1 and timeout of tag 0 together: timeout deferred one cycle
        issue(JX2_RBI_OPM_LDX, 48'h3200, 128'h0, 2'd0, a);
        step();
        issue(JX2_RBI_OPM_LDX, 48'h3300, 128'h0, 2'd1, a1);
        step();
        while (cyc < a + TMO) step();
        expQ.push_back('{2'd1, 128'h11, 1'b0, a + TMO + 1});
        expQ.push_back('{2'd0, 128'h0, 1'b1, a + TMO + 2});
        ring(16'h0040, 16'h1001, 48'h0, 128'h11);
        step();
        idle();
        repeat (4) step();

        // Own response frees the slot for a pending STX in the same cycle
        issue(JX2_RBI_OPM_LDX, 48'h4000, 128'h0, 2'd0, a);
        step();
        ring(16'h0093, 16'h2205, 48'h5, 128'h5);
        issue(JX2_RBI_OPM_STX, 48'h4100, 128'hCAFE, 2'd1, a);
        step();
        chkEgress("t5_busy_fwd", 16'h0093, 16'h2205, 48'h5, 128'h5);
        respond(16'h8040, 2'd0, 128'hCC);
        chkEgress("t5_inject", {1'b1, 7'b0000000, JX2_RBI_OPM_STX}, 16'h1001, 48'h4100, 128'hCAFE);
        respond(16'h0040, 2'd1, 128'hDD);
        step();

        // Reset with three tags outstanding
        for (int t = 0; t < 3; t++) begin
            issue(JX2_RBI_OPM_LDX, 48'h6000 + 48'(t), 128'h0, t[1:0], a);
            step();
        end
        ring(16'h0093, 16'h2207, 48'h7, 128'h7);
        reset = 1'b0;
        #1;
        chkAllZero("t6_reset_async");
        step();
        chkAllZero("t6_reset_held");
        idle();
        reset = 1'b1;
        step();
        ring(16'h0040, 16'h1001, 48'h0, 128'hEE);
        step();
        idle();
        chkEgress("t6_late_consumed", 16'h0000, 16'h0000, 48'h0, 128'h0);
        chk("t6_ready", 128'(reqReady), 128'h1);
        issue(JX2_RBI_OPM_LDX, 48'h7000, 128'h0, 2'd0, a);
        step();
        chkEgress("t6_inject", {8'h00, JX2_RBI_OPM_LDX}, 16'h1000, 48'h7000, 128'h0);
        respond(16'h0040, 2'd0, 128'hF0);

        repeat (5) step();
        chk("final_queue_empty", 128'(expQ.size()), 128'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
